// File: rtl/mix_state_sequencer_pkg.sv
// Shared definitions for the MixColumns state sequencer: FSM encoding,
// column index type, shared-unit latency and the GF(2^8) column transforms.
package mix_state_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  typedef logic [1:0] col_idx_t;

  // Register stages inside the shared single-column unit.
  localparam int unsigned MIX_LATENCY     = 32'd1;
  // Accept edge to out_valid: four columns fed plus the unit latency.
  localparam int unsigned ACCEPT_TO_VALID = 32'd4 + MIX_LATENCY;

  localparam col_idx_t FIRST_COL = 2'd0;
  localparam col_idx_t LAST_COL  = 2'd3;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small 4-bit constant (shift-and-add over the bits of k).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    gmul = acc;
  endfunction

  // Forward MixColumns on one column; byte 0 is the MSB byte.
  function automatic logic [31:0] mix_col_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    mix_col_fwd = {gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3,
                   a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3,
                   a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3),
                   gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2)};
  endfunction

  // Inverse MixColumns on one column; byte 0 is the MSB byte.
  function automatic logic [31:0] mix_col_inv(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    mix_col_inv = {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                   gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                   gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                   gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/mix_state_sequencer_mixcol.sv
// Shared single-column MixColumns unit: the column is registered on entry
// and the forward/inverse result is selected combinationally by inv.
module mixColumns
  import mix_state_sequencer_pkg::*;
(
  output logic [31:0] mixOut,
  input  logic [31:0] mixIn,
  input  logic        clk,
  input  logic        inv
);

  logic [31:0] col_q;

  // Input column register; intentionally unreset, its output is only
  // captured after a fresh column has been fed.
  always_ff @(posedge clk) begin
    col_q <= mixIn;
  end

  // Combinational mode select on the registered column.
  always_comb begin
    mixOut = 32'h0000_0000;
    if (inv) begin
      mixOut = mix_col_inv(col_q);
    end else begin
      mixOut = mix_col_fwd(col_q);
    end
  end

endmodule

// File: rtl/mix_state_sequencer.sv
// Feeds a 128-bit AES state through one shared MixColumns column unit,
// one column per cycle, and presents the registered result downstream.
module mix_state_sequencer
  import mix_state_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_state,
  output logic               busy,
  output logic [COUNT_W-1:0] blocks_done
);

  seq_state_e         state_q, state_d;
  col_idx_t           col_cnt_q, col_cnt_d;
  logic [127:0]       hold_state_q, hold_state_d;
  logic               hold_inv_q, hold_inv_d;
  logic [127:0]       result_q, result_d;
  logic [COUNT_W-1:0] blocks_q, blocks_d;

  logic               accept_s;
  logic               out_hs_s;
  logic               cap_en_s;
  col_idx_t           cap_idx_s;
  logic [31:0]        mix_in_s;
  logic [31:0]        mix_out_s;

  assign accept_s    = (state_q == ST_IDLE) && in_valid;
  assign out_hs_s    = (state_q == ST_DONE) && out_ready;
  assign out_state   = result_q;
  assign blocks_done = blocks_q;

  mixColumns u_mix (
    .mixOut (mix_out_s),
    .mixIn  (mix_in_s),
    .clk    (clk),
    .inv    (hold_inv_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_FEED;
        else          state_d = ST_IDLE;
      end
      ST_FEED: begin
        if (col_cnt_q == LAST_COL) state_d = ST_DRAIN;
        else                       state_d = ST_FEED;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_FEED:  out_valid = 1'b0;
      ST_DRAIN: out_valid = 1'b0;
      ST_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Column select mux feeding the shared unit from the holding register.
  always_comb begin
    mix_in_s = 32'h0000_0000;
    case (col_cnt_q)
      2'd0:    mix_in_s = hold_state_q[127:96];
      2'd1:    mix_in_s = hold_state_q[95:64];
      2'd2:    mix_in_s = hold_state_q[63:32];
      2'd3:    mix_in_s = hold_state_q[31:0];
      default: mix_in_s = 32'h0000_0000;
    endcase
  end

  // Result capture enable: the unit output lags the fed column by one cycle.
  always_comb begin
    cap_en_s  = 1'b0;
    cap_idx_s = FIRST_COL;
    if (state_q == ST_DRAIN) begin
      cap_en_s  = 1'b1;
      cap_idx_s = LAST_COL;
    end else if ((state_q == ST_FEED) && (col_cnt_q != FIRST_COL)) begin
      cap_en_s  = 1'b1;
      cap_idx_s = col_cnt_q - 2'd1;
    end else begin
      cap_en_s  = 1'b0;
      cap_idx_s = FIRST_COL;
    end
  end

  // Datapath next values: holding registers, column counter, result slots, block count.
  always_comb begin
    hold_state_d = hold_state_q;
    hold_inv_d   = hold_inv_q;
    col_cnt_d    = col_cnt_q;
    result_d     = result_q;
    blocks_d     = blocks_q;

    if (accept_s) begin
      hold_state_d = in_state;
      hold_inv_d   = in_inv;
      col_cnt_d    = FIRST_COL;
    end else if (state_q == ST_FEED) begin
      col_cnt_d = col_cnt_q + 2'd1;
    end else begin
      col_cnt_d = col_cnt_q;
    end

    if (cap_en_s) begin
      case (cap_idx_s)
        2'd0:    result_d[127:96] = mix_out_s;
        2'd1:    result_d[95:64]  = mix_out_s;
        2'd2:    result_d[63:32]  = mix_out_s;
        2'd3:    result_d[31:0]   = mix_out_s;
        default: result_d         = result_q;
      endcase
    end else begin
      result_d = result_q;
    end

    if (out_hs_s) begin
      blocks_d = blocks_q + COUNT_W'(1'b1);
    end else begin
      blocks_d = blocks_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_state_q <= 128'h0;
      hold_inv_q   <= 1'b0;
      col_cnt_q    <= FIRST_COL;
      result_q     <= 128'h0;
      blocks_q     <= '0;
    end else begin
      hold_state_q <= hold_state_d;
      hold_inv_q   <= hold_inv_d;
      col_cnt_q    <= col_cnt_d;
      result_q     <= result_d;
      blocks_q     <= blocks_d;
    end
  end

endmodule

// File: tb/tb_mix_state_sequencer.sv
// Directed self-checking bench for mix_state_sequencer with a 2-bit block counter.
module tb_mix_state_sequencer;

  localparam int CW = 2;

  localparam logic [127:0] VEC_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_AM = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_D  = 128'hd4d4d4d5_2d26314c_00000000_01010101;
  localparam logic [127:0] VEC_DM = 128'hd5d5d7d6_4d7ebdf8_00000000_01010101;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_state;
  logic          in_inv;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_state;
  logic          busy;
  logic [CW-1:0] blocks_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  mix_state_sequencer #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_inv      (in_inv),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .busy        (busy),
    .blocks_done (blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a state and wait for the accept edge; returns the cycle stamp of that edge.
  task automatic send(input logic [127:0] st, input logic iv, output int acc_cyc);
    logic r;
    logic ok;
    ok       = 1'b0;
    acc_cyc  = -1;
    in_state = st;
    in_inv   = iv;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = in_ready;
      step();
      if (r) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    chk("accept_seen", {127'd0, ok}, 128'd1);
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  int acc;
  int lat;
  int prev_acc;
  logic [127:0] b2b_in  [5];
  logic         b2b_inv [5];
  logic [127:0] b2b_exp [5];
  logic [1:0]   b2b_cnt [5];

  initial begin
    in_valid  = 1'b0;
    in_state  = 128'h0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy",      {127'd0, busy},      128'd0);
    chk("rst_out_state", out_state,           128'd0);
    chk("rst_blocks",    {126'd0, blocks_done}, 128'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Forward vector.
    send(VEC_A, 1'b0, acc);
    chk("fwd_busy", {127'd0, busy}, 128'd1);
    chk("fwd_in_ready_low", {127'd0, in_ready}, 128'd0);
    wait_valid(lat);
    chk("fwd_latency", 128'(lat), 128'd5);
    chk("fwd_state", out_state, VEC_AM);
    step();
    chk("fwd_blocks", {126'd0, blocks_done}, 128'd1);
    chk("fwd_in_ready_back", {127'd0, in_ready}, 128'd1);
    chk("fwd_out_valid_low", {127'd0, out_valid}, 128'd0);

    // Inverse vector.
    send(VEC_AM, 1'b1, acc);
    wait_valid(lat);
    chk("inv_latency", 128'(lat), 128'd5);
    chk("inv_state", out_state, VEC_A);
    step();
    chk("inv_blocks", {126'd0, blocks_done}, 128'd2);

    // Backpressure with in_inv toggled after the accept edge.
    out_ready = 1'b0;
    send(VEC_D, 1'b0, acc);
    in_inv = 1'b1;
    wait_valid(lat);
    chk("bp_latency", 128'(lat), 128'd5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_state", out_state, VEC_DM);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_blocks_hold", {126'd0, blocks_done}, 128'd2);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_blocks", {126'd0, blocks_done}, 128'd3);
    chk("bp_in_ready_back", {127'd0, in_ready}, 128'd1);

    // Reset while col_cnt is 2.
    send(VEC_D, 1'b0, acc);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mrst_in_ready",  {127'd0, in_ready},  128'd1);
    chk("mrst_busy",      {127'd0, busy},      128'd0);
    chk("mrst_blocks",    {126'd0, blocks_done}, 128'd0);
    step();
    chk("mrst_out_valid_held", {127'd0, out_valid}, 128'd0);
    chk("mrst_in_ready_held",  {127'd0, in_ready},  128'd1);
    rst_n = 1'b1;
    step();
    send(VEC_A, 1'b0, acc);
    wait_valid(lat);
    chk("mrst_latency", 128'(lat), 128'd5);
    chk("mrst_state", out_state, VEC_AM);
    step();
    chk("mrst_blocks_after", {126'd0, blocks_done}, 128'd1);

    // Back-to-back blocks from a fresh reset, alternating mode, counter wraps.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    b2b_in[0] = VEC_A;  b2b_inv[0] = 1'b0; b2b_exp[0] = VEC_AM; b2b_cnt[0] = 2'd1;
    b2b_in[1] = VEC_AM; b2b_inv[1] = 1'b1; b2b_exp[1] = VEC_A;  b2b_cnt[1] = 2'd2;
    b2b_in[2] = VEC_D;  b2b_inv[2] = 1'b0; b2b_exp[2] = VEC_DM; b2b_cnt[2] = 2'd3;
    b2b_in[3] = VEC_DM; b2b_inv[3] = 1'b1; b2b_exp[3] = VEC_D;  b2b_cnt[3] = 2'd0;
    b2b_in[4] = VEC_D;  b2b_inv[4] = 1'b0; b2b_exp[4] = VEC_DM; b2b_cnt[4] = 2'd1;
    prev_acc = -1;
    for (int b = 0; b < 5; b++) begin
      send(b2b_in[b], b2b_inv[b], acc);
      // Accept-to-accept: IDLE, four FEED, DRAIN, one DONE cycle.
      if (b > 0) chk("b2b_period", 128'(acc - prev_acc), 128'd7);
      prev_acc = acc;
      wait_valid(lat);
      chk("b2b_latency", 128'(lat), 128'd5);
      chk("b2b_state", out_state, b2b_exp[b]);
      step();
      chk("b2b_blocks", {126'd0, blocks_done}, {126'd0, b2b_cnt[b]});
      chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
